morph_stream_filter: RTL and testbench
======================================

MORPH_STREAM_FILTER -- requirements
Module: morph_stream_filter

Interface
REQ-001 SHALL have parameter IMG_W, default 64, meaning pixels per row (one row per memory word).
REQ-002 SHALL have parameter IMG_H, default 128, meaning rows per image; AW = $clog2(IMG_H) is derived, not overridable.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  asynchronous active-high reset.
REQ-004 SHALL have port start  in  1  one-cycle request to begin a pass.
REQ-005 SHALL have port mode  in  2  operation: 00 copy, 01 dilate, 10 erode, 11 gradient (dilate XOR erode).
REQ-006 SHALL have port se_sel  in  1  structuring element: 0 = 3x3 square, 1 = 3x3 cross.
REQ-007 SHALL have port src_addr  out  AW  source row address; src_data  in  IMG_W  source row, valid combinationally in the same cycle.
REQ-008 SHALL have port rd_req  out  1  high while the block owns the shared source read port.
REQ-009 SHALL have ports wr_en  out  1, wr_addr  out  AW, wr_data  out  IMG_W  result-row write to sink RAM.
REQ-010 SHALL have ports busy  out  1  pass in progress; done  out  1  one-cycle completion pulse.

Function
REQ-011 SHALL map bit c of a row word to column c.
REQ-012 SHALL latch mode and se_sel on the cycle start is accepted; later changes SHALL NOT affect the running pass.
REQ-013 SHALL accept start only in IDLE; start while busy SHALL be ignored.
REQ-014 SHALL implement FSM IDLE -> LOAD -> RUN -> FLUSH -> DONE -> IDLE.
REQ-015 LOAD (1 cycle): src_addr=0; capture src_data into row register cur; prev row set to neutral.
REQ-016 RUN (IMG_H cycles, r = 0..IMG_H-1): src_addr=r+1 while r+1<IMG_H; src_data is next row; when r=IMG_H-1 next row SHALL be neutral and src_addr held at IMG_H-1.
REQ-017 SHALL compute output row r from prev, cur, next combinationally, then shift prev<=cur, cur<=next.
REQ-018 Dilate: out[c] = OR of window pixels selected by se_sel; erode: AND over same pixels; copy: cur[c]; gradient: dilate[c] XOR erode[c].
REQ-019 Pixels outside the image (row -1, row IMG_H, column -1, column IMG_W) SHALL be neutral: 0 for dilation, 1 for erosion, each evaluated independently in gradient mode.
REQ-020 wr_en/wr_addr/wr_data SHALL be registered: row r written in the cycle after its RUN cycle, wr_addr=r.
REQ-021 FLUSH (1 cycle) SHALL emit the last write; DONE SHALL assert done for exactly one cycle, then IDLE.
REQ-022 With start accepted at cycle 0: LOAD cycle 1, RUN cycles 2..IMG_H+1, wr_en cycles 3..IMG_H+2, done cycle IMG_H+3.
REQ-023 busy SHALL be high from cycle 1 through the done cycle inclusive; rd_req SHALL be high in LOAD and RUN only.
REQ-024 wr_en SHALL be low outside the write window; wr_data/wr_addr SHALL be 0 when wr_en is low.

Reset
REQ-025 rst SHALL asynchronously force IDLE and drive busy, done, rd_req, wr_en, wr_addr, wr_data, src_addr to 0 and clear row registers.
REQ-026 rst mid-pass SHALL abort with no further writes; a new start after rst deasserts SHALL run a full pass from row 0.

Structure
REQ-027 Package morph_pkg SHALL hold the mode enum (COPY, DILATE, ERODE, GRADIENT) and the FSM state enum.
REQ-028 One combinational sub-module morph_row_kernel (inputs prev, cur, next, mode, se_sel; output row) SHALL implement REQ-018/019.

Verification (IMG_W=8, IMG_H=4)
REQ-029 Single pixel row1 bit3, dilate square -> rows 0..3 = 0x1C,0x1C,0x1C,0x00; start cycle 0 -> wr_en cycles 3..6, done cycle 7.
REQ-030 Same image, dilate cross -> 0x08,0x1C,0x08,0x00.
REQ-031 All rows 0xFF, erode square -> all 0xFF (border neutral); gradient -> all 0x00.
REQ-032 Single pixel, erode either element -> all 0x00; copy -> input rows unchanged.
REQ-033 start pulsed in cycle 4 of a pass and mode toggled mid-pass -> ignored, results match latched mode, single done.
REQ-034 rst asserted at cycle 4 -> outputs 0 immediately, no wr_en afterwards; subsequent start completes correct 4-row pass.

Source files
------------

// File: rtl/morph_pkg.sv
// morph_pkg: shared operation and state encodings for the morphology stream filter
package morph_pkg;
  typedef enum logic [1:0] {COPY, DILATE, ERODE, GRADIENT} mode_t;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, FLUSH, DONE} state_t;
endpackage

// File: rtl/morph_row_kernel.sv
// morph_row_kernel: one output row of 3x3 dilate/erode/gradient/copy from three input rows
module morph_row_kernel
  import morph_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [W-1:0] prev,
  input  logic [W-1:0] cur,
  input  logic [W-1:0] next,
  input  logic         prev_ok,
  input  logic         next_ok,
  input  logic [1:0]   mode,
  input  logic         se_sel,
  output logic [W-1:0] row
);
  logic [W-1:0] pd, nd, pe, ne, dv, ev, d, e;
  // missing rows read as 0 for dilation and 1 for erosion; column shifts fill likewise
  assign pd = prev & {W{prev_ok}};
  assign nd = next & {W{next_ok}};
  assign pe = prev | {W{~prev_ok}};
  assign ne = next | {W{~next_ok}};
  assign dv = pd | cur | nd;
  assign ev = pe & cur & ne;
  assign d = se_sel ? (pd | nd | cur | (cur << 1) | (cur >> 1))
                    : (dv | (dv << 1) | (dv >> 1));
  assign e = se_sel ? (pe & ne & cur & {cur[W-2:0], 1'b1} & {1'b1, cur[W-1:1]})
                    : (ev & {ev[W-2:0], 1'b1} & {1'b1, ev[W-1:1]});
  assign row = mode == COPY   ? cur :
               mode == DILATE ? d :
               mode == ERODE  ? e : d ^ e;
endmodule

// File: rtl/morph_stream_filter.sv
// morph_stream_filter: streams an image row by row through a 3x3 morphology kernel into a sink RAM
module morph_stream_filter
  import morph_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 128,
  localparam int AW = $clog2(IMG_H)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             se_sel,
  output logic [AW-1:0]    src_addr,
  input  logic [IMG_W-1:0] src_data,
  output logic             rd_req,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [IMG_W-1:0] wr_data,
  output logic             busy,
  output logic             done
);
  state_t           state;
  logic [AW-1:0]    r;
  logic [IMG_W-1:0] prev, cur, k_row;
  logic             prev_ok, se_q, last;
  mode_t            mode_q;
  assign last     = r == AW'(IMG_H - 1);
  assign src_addr = state == RUN ? (last ? r : r + 1'b1) : '0;
  assign rd_req   = state == LOAD || state == RUN;
  assign busy     = state != IDLE;
  assign done     = state == DONE;
  morph_row_kernel #(.W(IMG_W)) kernel (
    .prev(prev), .cur(cur), .next(src_data),
    .prev_ok(prev_ok), .next_ok(!last),
    .mode(mode_q), .se_sel(se_q), .row(k_row)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= IDLE;
      r       <= '0;
      prev    <= '0;
      cur     <= '0;
      prev_ok <= 1'b0;
      mode_q  <= COPY;
      se_q    <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      case (state)
        IDLE: if (start) begin
          state  <= LOAD;
          mode_q <= mode_t'(mode);
          se_q   <= se_sel;
        end
        LOAD: begin
          cur     <= src_data;
          prev    <= '0;
          prev_ok <= 1'b0;
          r       <= '0;
          state   <= RUN;
        end
        RUN: begin
          wr_en   <= 1'b1;
          wr_addr <= r;
          wr_data <= k_row;
          prev    <= cur;
          cur     <= src_data;
          prev_ok <= 1'b1;
          r       <= r + 1'b1;
          if (last) state <= FLUSH;
        end
        FLUSH:   state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_morph_stream_filter.sv
// tb_morph_stream_filter: directed vector and corner-sequence checks on an 8x4 image
module tb_morph_stream_filter;
  import morph_pkg::*;
  logic       clk = 0, rst = 1, start = 0, se_sel = 0;
  logic [1:0] mode = 0, src_addr, wr_addr;
  logic [7:0] src_data, wr_data;
  logic       rd_req, wr_en, busy, done;
  logic [7:0] mem [4];
  int checks = 0, failures = 0;

  morph_stream_filter #(.IMG_W(8), .IMG_H(4)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .se_sel(se_sel),
    .src_addr(src_addr), .src_data(src_data), .rd_req(rd_req),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  assign src_data = mem[src_addr];

  typedef struct {
    logic [1:0]  m;
    logic        s;
    logic [31:0] img;
    logic [31:0] exp;
    string       name;
  } vec_t;

  task automatic check(input string n, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", n, got, want);
    end
  endtask

  task automatic load_img(input logic [31:0] img);
    for (int i = 0; i < 4; i++) mem[i] = img[i*8 +: 8];
  endtask

  // start in cycle 0; expects LOAD c1, RUN c2..5, writes c3..6, done c7, idle after
  task automatic run_pass(input logic [1:0] m, input logic s, input logic [31:0] exp,
                          input bit meddle, input string name);
    int terr = 0;
    bit w;
    @(negedge clk);
    start = 1; mode = m; se_sel = s;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c == 1) start = 0;
      w = c >= 3 && c <= 6;
      if (busy !== (c <= 7) || done !== (c == 7) || rd_req !== (c <= 5) || wr_en !== w) terr++;
      if (w) check($sformatf("%s_row%0d", name, c - 3), {22'd0, wr_addr, wr_data},
                   {22'd0, 2'(c - 3), exp[(c-3)*8 +: 8]});
      else if (wr_addr !== 0 || wr_data !== 0) terr++;
      if (meddle && c == 4) begin start = 1; mode = ~m; se_sel = ~s; end
      if (meddle && c == 5) start = 0;
    end
    check({name, "_timing"}, terr, 0);
  endtask

  vec_t v [10];
  int err;

  initial begin
    v[0] = '{DILATE,   1'b0, 32'h0000_0800, 32'h001C_1C1C, "dil_sq"};
    v[1] = '{DILATE,   1'b1, 32'h0000_0800, 32'h0008_1C08, "dil_x"};
    v[2] = '{ERODE,    1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "ero_sq_ff"};
    v[3] = '{ERODE,    1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "ero_x_ff"};
    v[4] = '{GRADIENT, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, "grad_ff"};
    v[5] = '{ERODE,    1'b0, 32'h0000_0800, 32'h0000_0000, "ero_sq_px"};
    v[6] = '{ERODE,    1'b1, 32'h0000_0800, 32'h0000_0000, "ero_x_px"};
    v[7] = '{COPY,     1'b0, 32'h7E81_3CA5, 32'h7E81_3CA5, "copy"};
    v[8] = '{DILATE,   1'b0, 32'h0000_0001, 32'h0000_0303, "dil_corner"};
    v[9] = '{DILATE,   1'b1, 32'h8000_0000, 32'hC080_0000, "dil_x_edge"};
    load_img(0);
    #1;
    check("reset_outputs", {busy, done, rd_req, wr_en, wr_addr, wr_data, src_addr}, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    foreach (v[i]) begin
      load_img(v[i].img);
      run_pass(v[i].m, v[i].s, v[i].exp, 1'b0, v[i].name);
    end
    load_img(32'h7E7E_7E7E);
    run_pass(ERODE, 1'b0, 32'h3C3C_3C3C, 1'b0, "ero_sq_7e");
    load_img(32'h0000_0800);
    run_pass(GRADIENT, 1'b0, 32'h001C_1C1C, 1'b0, "grad_px");
    run_pass(DILATE, 1'b0, 32'h001C_1C1C, 1'b1, "start_ignored");
    // abort mid-pass with an asynchronous reset during a write cycle
    @(negedge clk);
    start = 1; mode = DILATE; se_sel = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) start = 0;
    end
    check("pre_rst_wr_en", wr_en, 1);
    #1 rst = 1;
    #1 check("async_rst_outputs", {busy, done, rd_req, wr_en, wr_addr, wr_data, src_addr}, 0);
    err = 0;
    repeat (3) begin
      @(negedge clk);
      if (wr_en !== 0 || busy !== 0 || done !== 0) err++;
    end
    rst = 0;
    repeat (4) begin
      @(negedge clk);
      if (wr_en !== 0 || busy !== 0 || done !== 0) err++;
    end
    check("post_rst_quiet", err, 0);
    run_pass(DILATE, 1'b1, 32'h0008_1C08, 1'b0, "after_rst");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
